stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Parametrised successor to the core's instruction-stage FSM.
- Sequences a one-hot stage vector through NUM_STAGES stages, holding each stage for a configurable DWELL cycles, with a stall input that extends the final dwell cycle.
- Prioritises faults from fetch, memory and decode into a cause code, and redirects to the control stage (stage 0) on a fault.
- Arbitrates NUM_IRQ maskable external interrupts plus a software interrupt into a control operation for the control stage.

Parameters:
- NUM_STAGES, 6, number of stages; stage 0 is the control stage. Must be >= 3.
- DWELL, 2, cycles spent in each stage. Must be >= 1.
- FETCH_STAGE, 1, stage index in which fetch memory faults are honoured.
- MEMORY_STAGE, 4, stage index in which load/store memory faults are honoured.
- NUM_IRQ, 4, number of external interrupt lines. Must be >= 1.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active low
- stall  in  1  hold the current stage on its final dwell cycle
- illegal_instr_fault  in  1  illegal instruction, honoured in any stage except 0
- mem_addr_fault  in  1  misaligned address
- mem_access_fault  in  1  access fault
- mem_fault_is_store  in  1  memory fault belongs to a store
- ext_irq  in  NUM_IRQ  external interrupt requests, level sensitive
- irq_mask  in  NUM_IRQ  1 = line enabled
- sw_int  in  1  software interrupt
- stage_active  out  NUM_STAGES  one-hot current stage
- commit  out  1  current cycle is the stage's final, unstalled cycle
- control_op  out  2  00 trap, 01 ext_int, 10 sw_int, 11 normal
- irq_id  out  $clog2(NUM_IRQ) (min 1)  winning interrupt line
- fault_num  out  3  latched fault cause
- trap_taken  out  1  one-cycle pulse, registered, cycle after a fault commit
- retire  out  1  one-cycle pulse, registered, cycle after an unfaulted commit of stage NUM_STAGES-1

Behaviour:
- Reset (asynchronous, any time, including mid-stage or mid-stall):
  - stage_active = 1, dwell count = 0, control_op = 11, irq_id = 0, fault_num = 000, trap_taken = 0, retire = 0.
- Dwell counter, range 0..DWELL-1:
  - Increments each cycle until it reaches DWELL-1, then holds there while stall = 1.
  - commit = (count == DWELL-1) & ~stall; this is combinational from the counter and stall.
  - On commit, the counter returns to 0.
  - DWELL = 1 means commit = ~stall.
- Stall is ignored on non-final dwell cycles; the count advances regardless.
- Faults are sampled only on commit, never on non-commit cycles:
  - Fetch memory fault: mem_addr_fault or mem_access_fault while in FETCH_STAGE.
  - Memory-stage memory fault: mem_addr_fault or mem_access_fault while in MEMORY_STAGE.
  - Illegal instruction: illegal_instr_fault while in any stage other than 0.
- Fault priority and fault_num codes (highest priority first):
  - illegal instruction: 010
  - address fault (addr beats access when both are set): fetch 000, load 100, store 110
  - access fault: fetch 001, load 101, store 111
- On a fault commit, the next cycle shows:
  - stage_active = 1, control_op = 00, fault_num = the new code, trap_taken = 1.
  - irq_id holds its value.
- On an unfaulted commit: stage_active rotates left by one, wrapping from bit NUM_STAGES-1 to bit 0.
- Control-op update happens on an unfaulted commit of stage NUM_STAGES-1:
  - If (ext_irq & irq_mask) != 0: control_op = 01 and irq_id = index of the lowest set bit.
  - Else if sw_int: control_op = 10.
  - Else: control_op = 11.
  - retire = 1 in the following cycle.
- Interrupt inputs are ignored at every other time. control_op, irq_id and fault_num hold otherwise.
- fault_num is sticky until the next fault commit.
- Simultaneous fault and interrupt on the same commit: the fault wins and no interrupt is recorded.

Decomposition:
- stage_seq_pkg holds:
  - the control_op enum (CTRL_TRAP, CTRL_EXT_INT, CTRL_SW_INT, CTRL_NORMAL);
  - the fault cause localparams (FAULT_IADDR = 000, FAULT_IACCESS = 001, FAULT_ILLEGAL = 010, FAULT_LADDR = 100, FAULT_LACCESS = 101, FAULT_SADDR = 110, FAULT_SACCESS = 111).
- One sub-module, stage_dwell_counter (parameter DWELL; inputs clk, reset_n, stall; output commit).
- Interrupt priority is a combinational find-first-set inside the top module.

Test Plan:
- Defaults, no stall, no faults, 12 cycles after reset release -> stage_active steps 1, 2, 4, 8, 16, 32, each held 2 cycles; retire pulses once; control_op = 11.
- stall held 3 cycles on the second cycle of stage 2 -> stage_active stays 4 for 5 cycles total; commit stays 0 while stall is high.
- In stage 4 on commit: mem_addr_fault = 1 and mem_fault_is_store = 1 -> next cycle stage_active = 1, control_op = 00, fault_num = 110, trap_taken = 1.
- In stage 1 on commit: illegal_instr_fault = 1 and mem_access_fault = 1 -> fault_num = 010. Illegal_instr_fault asserted only in stage 0 -> no trap.
- ext_irq = 1010, irq_mask = 1110, sw_int = 1 at the stage-5 commit -> control_op = 01, irq_id = 1. With irq_mask = 0000 -> control_op = 10.
- reset_n dropped asynchronously mid-stall in stage 3 -> all outputs go to reset values at once without a clock edge; after release the sequence restarts from stage 0 with a full dwell.

Source files
------------

// File: rtl/stage_seq_pkg.sv
// Shared definitions for the stage sequencer.
//   ctrl_op_e   : control operation presented to the control stage
//   FAULT_*     : fault cause codes latched into fault_num
//   fault_code  : maps the fault sources to a cause code using the priority
//                 order illegal > address > access
package stage_seq_pkg;

    typedef enum logic [1:0] {
        CTRL_TRAP    = 2'b00,
        CTRL_EXT_INT = 2'b01,
        CTRL_SW_INT  = 2'b10,
        CTRL_NORMAL  = 2'b11
    } ctrl_op_e;

    localparam logic [2:0] FAULT_IADDR   = 3'b000;
    localparam logic [2:0] FAULT_IACCESS = 3'b001;
    localparam logic [2:0] FAULT_ILLEGAL = 3'b010;
    localparam logic [2:0] FAULT_LADDR   = 3'b100;
    localparam logic [2:0] FAULT_LACCESS = 3'b101;
    localparam logic [2:0] FAULT_SADDR   = 3'b110;
    localparam logic [2:0] FAULT_SACCESS = 3'b111;

    // Only meaningful when at least one fault source is active. A memory
    // fault that is not a fetch fault belongs to the memory stage.
    function automatic logic [2:0] fault_code(
        input logic illegal,
        input logic fetch,
        input logic store,
        input logic addr
    );
        if (illegal)
            return FAULT_ILLEGAL;
        if (fetch)
            return addr ? FAULT_IADDR : FAULT_IACCESS;
        if (store)
            return addr ? FAULT_SADDR : FAULT_SACCESS;
        return addr ? FAULT_LADDR : FAULT_LACCESS;
    endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Signal bundle between the stage sequencer and its environment.
//   master : environment side, drives stall, fault and interrupt inputs
//   slave  : sequencer side, drives stage_active, commit, control_op,
//            irq_id, fault_num, trap_taken and retire
interface stage_sequencer_if
    import stage_seq_pkg::*;
#(
    parameter int NUM_STAGES = 6,
    parameter int NUM_IRQ    = 4
) ();

    localparam int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic                  stall;
    logic                  illegal_instr_fault;
    logic                  mem_addr_fault;
    logic                  mem_access_fault;
    logic                  mem_fault_is_store;
    logic [NUM_IRQ-1:0]    ext_irq;
    logic [NUM_IRQ-1:0]    irq_mask;
    logic                  sw_int;

    logic [NUM_STAGES-1:0] stage_active;
    logic                  commit;
    ctrl_op_e              control_op;
    logic [IRQ_W-1:0]      irq_id;
    logic [2:0]            fault_num;
    logic                  trap_taken;
    logic                  retire;

    modport master (
        output stall, illegal_instr_fault, mem_addr_fault, mem_access_fault,
               mem_fault_is_store, ext_irq, irq_mask, sw_int,
        input  stage_active, commit, control_op, irq_id, fault_num,
               trap_taken, retire
    );

    modport slave (
        input  stall, illegal_instr_fault, mem_addr_fault, mem_access_fault,
               mem_fault_is_store, ext_irq, irq_mask, sw_int,
        output stage_active, commit, control_op, irq_id, fault_num,
               trap_taken, retire
    );

endinterface

// File: rtl/stage_dwell_counter.sv
// Dwell counter for one stage.
//   clk, reset_n : clock, asynchronous active-low reset
//   stall        : holds the count on the final dwell cycle
//   commit       : final, unstalled dwell cycle (combinational)
// The count runs 0..DWELL-1; stall only matters on the last count, earlier
// counts advance regardless.
module stage_dwell_counter #(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic stall,
    output logic commit
);

    localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          at_last;

    // With DWELL = 1 the counter sits at zero and commit reduces to ~stall.
    assign at_last = (count_q == LAST);
    assign commit  = at_last & ~stall;

    always_comb begin
        count_d = count_q;
        if (commit)
            count_d = '0;
        else if (!at_last)
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/stage_sequencer.sv
// Parametrised instruction-stage sequencer.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : stall/fault/interrupt inputs; one-hot stage_active,
//                  commit, control_op, irq_id, fault_num, trap_taken, retire
// A one-hot stage token advances on every unfaulted commit. A fault on a
// commit sends the token back to the control stage (bit 0) with a trap; an
// unfaulted commit of the last stage picks the next control operation from
// the masked external interrupts and the software interrupt.
module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter int NUM_STAGES   = 6,
    parameter int DWELL        = 2,
    parameter int FETCH_STAGE  = 1,
    parameter int MEMORY_STAGE = 4,
    parameter int NUM_IRQ      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    stage_sequencer_if.slave   bus
);

    localparam int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic                  commit;
    logic [NUM_STAGES-1:0] stage_active_q, stage_active_d;
    ctrl_op_e              control_op_q, control_op_d;
    logic [IRQ_W-1:0]      irq_id_q, irq_id_d;
    logic [2:0]            fault_num_q, fault_num_d;
    logic                  trap_taken_q, trap_taken_d;
    logic                  retire_q, retire_d;

    stage_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (bus.stall),
        .commit  (commit)
    );

    // Fault qualification against the current stage
    logic mem_fault_any;
    logic illegal_hit;
    logic fetch_hit;
    logic mem_hit;
    logic fault_hit;
    logic [2:0] fault_new;

    assign mem_fault_any = bus.mem_addr_fault | bus.mem_access_fault;
    assign illegal_hit   = bus.illegal_instr_fault & ~stage_active_q[0];
    assign fetch_hit     = mem_fault_any & stage_active_q[FETCH_STAGE];
    assign mem_hit       = mem_fault_any & stage_active_q[MEMORY_STAGE];
    assign fault_hit     = illegal_hit | fetch_hit | mem_hit;
    assign fault_new     = fault_code(illegal_hit, fetch_hit,
                                      bus.mem_fault_is_store, bus.mem_addr_fault);

    // Lowest-numbered enabled interrupt wins: scan from the top down so the
    // last assignment made is the lowest set bit.
    logic [NUM_IRQ-1:0] irq_pending;
    logic [IRQ_W-1:0]   irq_win;

    assign irq_pending = bus.ext_irq & bus.irq_mask;

    always_comb begin
        irq_win = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_pending[i])
                irq_win = IRQ_W'(i);
        end
    end

    always_comb begin
        stage_active_d = stage_active_q;
        control_op_d   = control_op_q;
        irq_id_d       = irq_id_q;
        fault_num_d    = fault_num_q;
        trap_taken_d   = 1'b0;
        retire_d       = 1'b0;

        if (commit) begin
            if (fault_hit) begin
                // Fault beats any interrupt on the same commit; irq_id holds.
                stage_active_d = NUM_STAGES'(1);
                control_op_d   = CTRL_TRAP;
                fault_num_d    = fault_new;
                trap_taken_d   = 1'b1;
            end else begin
                stage_active_d = {stage_active_q[NUM_STAGES-2:0],
                                  stage_active_q[NUM_STAGES-1]};
                if (stage_active_q[NUM_STAGES-1]) begin
                    retire_d = 1'b1;
                    if (|irq_pending) begin
                        control_op_d = CTRL_EXT_INT;
                        irq_id_d     = irq_win;
                    end else if (bus.sw_int) begin
                        control_op_d = CTRL_SW_INT;
                    end else begin
                        control_op_d = CTRL_NORMAL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_active_q <= NUM_STAGES'(1);
            control_op_q   <= CTRL_NORMAL;
            irq_id_q       <= '0;
            fault_num_q    <= FAULT_IADDR;
            trap_taken_q   <= 1'b0;
            retire_q       <= 1'b0;
        end else begin
            stage_active_q <= stage_active_d;
            control_op_q   <= control_op_d;
            irq_id_q       <= irq_id_d;
            fault_num_q    <= fault_num_d;
            trap_taken_q   <= trap_taken_d;
            retire_q       <= retire_d;
        end
    end

    assign bus.stage_active = stage_active_q;
    assign bus.commit       = commit;
    assign bus.control_op   = control_op_q;
    assign bus.irq_id       = irq_id_q;
    assign bus.fault_num    = fault_num_q;
    assign bus.trap_taken   = trap_taken_q;
    assign bus.retire       = retire_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer with default parameters.
// The stimulus process sets inputs just after each rising edge and pushes the
// expected outputs of that cycle; the monitor pops and compares on the
// falling edge.
module tb_stage_sequencer;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    stage_sequencer_if #(.NUM_STAGES(6), .NUM_IRQ(4)) bus ();

    stage_sequencer #(
        .NUM_STAGES   (6),
        .DWELL        (2),
        .FETCH_STAGE  (1),
        .MEMORY_STAGE (4),
        .NUM_IRQ      (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int         cyc;
        logic [5:0] stage;
        logic       commit;
        logic [1:0] op;
        logic [1:0] irq;
        logic [2:0] fn;
        logic       trap;
        logic       retire;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_no   = 0;

    // Held expectations, updated by hand where the sequence changes them
    logic [1:0] e_op  = 2'b11;
    logic [1:0] e_irq = 2'b00;
    logic [2:0] e_fn  = 3'b000;

    task automatic cyc(input int s, input bit cm, input bit tt, input bit rt);
        exp_t e;
        e.cyc    = cyc_no;
        e.stage  = 6'(1 << s);
        e.commit = cm;
        e.op     = e_op;
        e.irq    = e_irq;
        e.fn     = e_fn;
        e.trap   = tt;
        e.retire = rt;
        exp_q.push_back(e);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input int s);
        cyc(s, 1'b0, 1'b0, 1'b0);
        cyc(s, 1'b1, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.stage_active === e.stage && bus.commit === e.commit &&
                bus.control_op === e.op && bus.irq_id === e.irq &&
                bus.fault_num === e.fn && bus.trap_taken === e.trap &&
                bus.retire === e.retire) begin
                n_pass++;
            end else begin
                $display("FAIL cycle%0d: got stage=%b commit=%b op=%b irq=%0d fault=%b trap=%b retire=%b, want stage=%b commit=%b op=%b irq=%0d fault=%b trap=%b retire=%b",
                         e.cyc, bus.stage_active, bus.commit, bus.control_op,
                         bus.irq_id, bus.fault_num, bus.trap_taken, bus.retire,
                         e.stage, e.commit, e.op, e.irq, e.fn, e.trap, e.retire);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        reset_n                 = 1'b0;
        bus.stall               = 1'b0;
        bus.illegal_instr_fault = 1'b0;
        bus.mem_addr_fault      = 1'b0;
        bus.mem_access_fault    = 1'b0;
        bus.mem_fault_is_store  = 1'b0;
        bus.ext_irq             = 4'b0000;
        bus.irq_mask            = 4'b0000;
        bus.sw_int              = 1'b0;

        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0);            // in reset
        cyc(0, 0, 0, 0);
        reset_n = 1'b1;
        cyc_no  = 0;

        // Free run through all six stages, one retire
        for (int s = 0; s < 6; s++) pair(s);            // cycles 0-11
        cyc(0, 0, 0, 1);                                // 12 retire
        cyc(0, 1, 0, 0);
        pair(1);

        // Stall on the final dwell cycle of stage 2
        cyc(2, 0, 0, 0);
        bus.stall = 1'b1;
        cyc(2, 0, 0, 0);
        cyc(2, 0, 0, 0);
        cyc(2, 0, 0, 0);
        bus.stall = 1'b0;
        cyc(2, 1, 0, 0);
        // Stall on a non-final cycle is ignored
        bus.stall = 1'b1;
        cyc(3, 0, 0, 0);
        bus.stall = 1'b0;
        cyc(3, 1, 0, 0);

        // Store address fault in the memory stage
        cyc(4, 0, 0, 0);
        bus.mem_addr_fault     = 1'b1;
        bus.mem_fault_is_store = 1'b1;
        cyc(4, 1, 0, 0);
        bus.mem_addr_fault     = 1'b0;
        bus.mem_fault_is_store = 1'b0;
        e_op = 2'b00;
        e_fn = 3'b110;
        cyc(0, 0, 1, 0);

        // Illegal in stage 0 and on a non-commit cycle: no trap
        bus.illegal_instr_fault = 1'b1;
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        // Illegal beats a fetch access fault
        bus.mem_access_fault = 1'b1;
        cyc(1, 1, 0, 0);
        bus.illegal_instr_fault = 1'b0;
        bus.mem_access_fault    = 1'b0;
        e_fn = 3'b010;
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        for (int s = 1; s < 4; s++) pair(s);

        // External interrupt: ignored on stage 4 commit, taken on stage 5
        bus.ext_irq  = 4'b1010;
        bus.irq_mask = 4'b1110;
        bus.sw_int   = 1'b1;
        pair(4);
        pair(5);
        bus.ext_irq  = 4'b0000;
        bus.irq_mask = 4'b0000;
        bus.sw_int   = 1'b0;
        e_op  = 2'b01;
        e_irq = 2'd1;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int s = 1; s < 5; s++) pair(s);

        // Masked external interrupts: software interrupt wins
        bus.ext_irq  = 4'b1010;
        bus.irq_mask = 4'b0000;
        bus.sw_int   = 1'b1;
        pair(5);
        bus.ext_irq = 4'b0000;
        bus.sw_int  = 1'b0;
        e_op = 2'b10;
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int s = 1; s < 5; s++) pair(s);

        // Fault and interrupt on the same stage-5 commit: fault wins
        cyc(5, 0, 0, 0);
        bus.illegal_instr_fault = 1'b1;
        bus.ext_irq             = 4'b0100;
        bus.irq_mask            = 4'b1111;
        bus.sw_int              = 1'b1;
        cyc(5, 1, 0, 0);
        bus.illegal_instr_fault = 1'b0;
        bus.ext_irq             = 4'b0000;
        bus.irq_mask            = 4'b0000;
        bus.sw_int              = 1'b0;
        e_op = 2'b00;
        e_fn = 3'b010;
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);

        // Fetch access fault
        cyc(1, 0, 0, 0);
        bus.mem_access_fault = 1'b1;
        cyc(1, 1, 0, 0);
        bus.mem_access_fault = 1'b0;
        e_fn = 3'b001;
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        for (int s = 1; s < 4; s++) pair(s);

        // Load access fault in the memory stage
        cyc(4, 0, 0, 0);
        bus.mem_access_fault = 1'b1;
        cyc(4, 1, 0, 0);
        bus.mem_access_fault = 1'b0;
        e_fn = 3'b101;
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        pair(1);
        pair(2);

        // Asynchronous reset mid-stall in stage 3
        cyc(3, 0, 0, 0);
        bus.stall = 1'b1;
        cyc(3, 0, 0, 0);
        #1;
        reset_n = 1'b0;
        e_op  = 2'b11;
        e_irq = 2'd0;
        e_fn  = 3'b000;
        cyc(0, 0, 0, 0);            // checked before any clock edge
        bus.stall = 1'b0;
        cyc(0, 0, 0, 0);
        reset_n = 1'b1;
        cyc(0, 0, 0, 0);            // full dwell after release
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
